// File: rtl/cpu_mem_if.sv
// CPU-side request/response bus between the core and its memory stage.
// The memory stage takes the slave view; the core (or a testbench) takes the master view.
interface cpu_mem_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req_rdwr;
  logic              which_rdwr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic              cpu_enable;

  modport master (
    output req_rdwr,
    output which_rdwr,
    output addr,
    output data_out,
    input  data_in,
    input  cpu_enable
  );

  modport slave (
    input  req_rdwr,
    input  which_rdwr,
    input  addr,
    input  data_out,
    output data_in,
    output cpu_enable
  );
endinterface

// File: rtl/cpu_mem_bridge.sv
// CPU memory stage: byte RAM behind a posted-write FIFO, one-wait-state reads.
// Define CPU_MEM_BRIDGE_FWD_EN to let reads forward from the FIFO instead of waiting for it to drain.
module cpu_mem_bridge #(
  parameter int   ADDR_W     = 16,
  parameter int   DATA_W     = 8,
  parameter int   MEM_ADDR_W = 12,
  parameter int   WBUF_DEPTH = 4,
  parameter logic WH_READ    = 1'b0,
  parameter logic WH_WRITE   = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  cpu_mem_if.slave  bus,
  input  logic      drain_hold,
  output logic      wbuf_empty
);

  localparam int IDX_W = (MEM_ADDR_W < ADDR_W) ? MEM_ADDR_W : ADDR_W;
  localparam int RAM_N = 1 << IDX_W;
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mem     [RAM_N];
  logic [IDX_W-1:0]  wb_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data [WBUF_DEPTH];

  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] ram_q, fwd_q, hold_q, rd_val;
  logic              fwd_sel;

  logic [IDX_W-1:0]  idx;
  logic              full, is_rd, is_wr, can_drain;
  logic              enq, drain, rd_go, ram_rd;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign idx        = bus.addr[IDX_W-1:0];
  assign full       = count == CNT_W'(WBUF_DEPTH);
  assign wbuf_empty = count == '0;
  assign can_drain  = !wbuf_empty && !drain_hold;
  assign is_rd      = bus.req_rdwr && (bus.which_rdwr == WH_READ);
  assign is_wr      = bus.req_rdwr && (bus.which_rdwr == WH_WRITE);
  assign rd_val     = fwd_sel ? fwd_q : ram_q;

`ifdef CPU_MEM_BRIDGE_FWD_EN
  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (CNT_W'(i) < count &&
          wb_addr[head + PTR_W'(i)] == idx) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[head + PTR_W'(i)];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    state_n        = state;
    bus.cpu_enable = 1'b1;
    bus.data_in    = hold_q;
    enq            = 1'b0;
    drain          = 1'b0;
    rd_go          = 1'b0;
    ram_rd         = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          is_wr: begin
            bus.cpu_enable = !full;
            enq            = !full;
            drain          = can_drain;
          end
          is_rd: begin
            bus.cpu_enable = 1'b0;
`ifdef CPU_MEM_BRIDGE_FWD_EN
            rd_go  = 1'b1;
            ram_rd = !fwd_hit;
            drain  = fwd_hit && can_drain;
`else
            rd_go  = wbuf_empty;
            ram_rd = wbuf_empty;
            drain  = can_drain;
`endif
            if (rd_go) state_n = RD_WAIT;
          end
          default: drain = can_drain;
        endcase
      end
      RD_WAIT: begin
        bus.data_in = rd_val;
        drain       = can_drain;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      hold_q  <= '0;
      ram_q   <= '0;
      fwd_q   <= '0;
      fwd_sel <= 1'b0;
    end else begin
      state <= state_n;
      count <= count + CNT_W'(enq) - CNT_W'(drain);
      if (enq)   tail <= tail + PTR_W'(1);
      if (drain) head <= head + PTR_W'(1);
      if (rd_go) begin
        fwd_sel <= fwd_hit;
        fwd_q   <= fwd_data;
      end
      if (ram_rd) ram_q <= mem[idx];
      if (state == RD_WAIT) hold_q <= rd_val;
    end
  end

  // Storage arrays carry no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      wb_addr[tail] <= idx;
      wb_data[tail] <= bus.data_out;
    end
    if (drain) mem[wb_addr[head]] <= wb_data[head];
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: directed scenarios plus random traffic
// against an architectural memory model.
module tb_cpu_mem_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drain_hold = 1'b0;
  logic wbuf_empty;

  int total = 0;
  int bad = 0;

  logic [7:0] ref_mem [4096];
  bit         known   [4096];
  logic [7:0] last_rd;

  cpu_mem_if bus ();

  cpu_mem_bridge dut (
    .clk        (clk),
    .rst        (rst_n),
    .bus        (bus),
    .drain_hold (drain_hold),
    .wbuf_empty (wbuf_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_op(input logic wr,
                        input logic [15:0] a,
                        input logic [7:0] d,
                        output int waits,
                        output logic [7:0] rd);
    @(negedge clk);
    bus.req_rdwr   = 1'b1;
    bus.which_rdwr = wr;
    bus.addr       = a;
    bus.data_out   = d;
    #1;
    waits = 0;
    while (bus.cpu_enable !== 1'b1 && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    rd = bus.data_in;
    @(posedge clk);
    #1;
    bus.req_rdwr = 1'b0;
  endtask

  task automatic wr_op(input logic [15:0] a,
                       input logic [7:0] d,
                       input string tag);
    int w;
    logic [7:0] r;
    logic [11:0] i;
    cpu_op(1'b1, a, d, w, r);
    chk({tag, "_wait"}, 32'(w), 32'd0);
    i = a[11:0];
    ref_mem[i] = d;
    known[i] = 1'b1;
  endtask

  // exp_w < 0: wait count only bounded (read may sit behind a drain).
  task automatic rd_op(input logic [15:0] a,
                       input int exp_w,
                       input string tag);
    int w;
    logic [7:0] r;
    logic [11:0] i;
    cpu_op(1'b0, a, 8'h00, w, r);
    if (exp_w >= 0)
      chk({tag, "_wait"}, 32'(w), 32'(exp_w));
    else
      chk({tag, "_wait_rng"}, 32'(w >= 1 && w <= 5), 32'd1);
    i = a[11:0];
    if (known[i]) chk({tag, "_data"}, 32'(r), 32'(ref_mem[i]));
    last_rd = r;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

`ifdef CPU_MEM_BRIDGE_FWD_EN
  localparam int RDW = 1;
`else
  localparam int RDW = -1;
`endif

  initial begin
    int w;
    logic [7:0] old30;
    logic [7:0] d3 [5];
    logic [15:0] a;

    bus.req_rdwr   = 1'b0;
    bus.which_rdwr = 1'b0;
    bus.addr       = '0;
    bus.data_out   = '0;

    // 1: reset state, then idle after release
    repeat (3) @(posedge clk);
    #1;
    chk("t1_rst_din", 32'(bus.data_in), 32'h00);
    chk("t1_rst_en", 32'(bus.cpu_enable), 32'd1);
    chk("t1_rst_empty", 32'(wbuf_empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("t1_idle_din", 32'(bus.data_in), 32'h00);
    chk("t1_idle_en", 32'(bus.cpu_enable), 32'd1);
    chk("t1_idle_empty", 32'(wbuf_empty), 32'd1);

    // 2: back-to-back stores, then reads with one wait each
    wr_op(16'h0010, 8'h45, "t2_w10");
    wr_op(16'h0011, 8'h87, "t2_w11");
    wr_op(16'h0012, 8'hAA, "t2_w12");
    idle(3);
    rd_op(16'h0010, 1, "t2_r10");
    rd_op(16'h0011, 1, "t2_r11");
    rd_op(16'h0012, 1, "t2_r12");
    idle(2);
    chk("t2_din_stable", 32'(bus.data_in), 32'hAA);

    // 3: full FIFO stalls the fifth store until drain release
    drain_hold = 1'b1;
    for (int k = 0; k < 5; k++) d3[k] = 8'($urandom);
    for (int k = 0; k < 4; k++)
      wr_op(16'h0040 + 16'(k), d3[k], "t3_fill");
    chk("t3_not_empty", 32'(wbuf_empty), 32'd0);
    @(negedge clk);
    bus.req_rdwr   = 1'b1;
    bus.which_rdwr = 1'b1;
    bus.addr       = 16'h0044;
    bus.data_out   = d3[4];
    #1;
    chk("t3_full_stall", 32'(bus.cpu_enable), 32'd0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("t3_full_stall", 32'(bus.cpu_enable), 32'd0);
    end
    @(negedge clk);
    drain_hold = 1'b0;
    #1;
    chk("t3_release_cyc", 32'(bus.cpu_enable), 32'd0);
    @(negedge clk);
    #1;
    chk("t3_accept_next", 32'(bus.cpu_enable), 32'd1);
    @(posedge clk);
    #1;
    bus.req_rdwr = 1'b0;
    ref_mem[12'h044] = d3[4];
    known[12'h044] = 1'b1;
    w = 0;
    while (wbuf_empty !== 1'b1 && w < 5) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("t3_drained", 32'(wbuf_empty), 32'd1);
    rd_op(16'h0044, 1, "t3_r44");
    rd_op(16'h0040, 1, "t3_r40");

    // 4: read behind two posted writes to the same address
    drain_hold = 1'b1;
    wr_op(16'h0020, 8'h11, "t4_w1");
    wr_op(16'h0020, 8'h22, "t4_w2");
`ifdef CPU_MEM_BRIDGE_FWD_EN
    rd_op(16'h0020, 1, "t4_fwd");
    chk("t4_fifo_held", 32'(wbuf_empty), 32'd0);
    drain_hold = 1'b0;
`else
    @(negedge clk);
    bus.req_rdwr   = 1'b1;
    bus.which_rdwr = 1'b0;
    bus.addr       = 16'h0020;
    #1;
    chk("t4_stall", 32'(bus.cpu_enable), 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("t4_stall", 32'(bus.cpu_enable), 32'd0);
    end
    chk("t4_fifo_held", 32'(wbuf_empty), 32'd0);
    @(negedge clk);
    drain_hold = 1'b0;
    #1;
    w = 0;
    while (bus.cpu_enable !== 1'b1 && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("t4_release_bound", 32'(w < 20), 32'd1);
    chk("t4_data", 32'(bus.data_in), 32'h22);
    @(posedge clk);
    #1;
    bus.req_rdwr = 1'b0;
`endif
    idle(6);
    chk("t4_drained", 32'(wbuf_empty), 32'd1);

    // 5: upper address bits alias onto the RAM index
    wr_op(16'h1005, 8'h5A, "t5_w");
    rd_op(16'h0005, RDW, "t5_r0005");
    rd_op(16'h2005, 1, "t5_r2005");

    // 6: reset discards posted writes, RAM keeps its contents
    wr_op(16'h0030, 8'h01, "t6_w01");
    idle(3);
    old30 = ref_mem[12'h030];
    drain_hold = 1'b1;
    wr_op(16'h0030, 8'h99, "t6_w99");
    chk("t6_pending", 32'(wbuf_empty), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_empty", 32'(wbuf_empty), 32'd1);
    chk("t6_rst_din", 32'(bus.data_in), 32'h00);
    chk("t6_rst_en", 32'(bus.cpu_enable), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drain_hold = 1'b0;
    ref_mem[12'h030] = old30;
    idle(2);
    rd_op(16'h0030, 1, "t6_r30");

    // random traffic against the architectural memory model
    for (int n = 0; n < 120; n++) begin
      a = 16'h0080 + 16'($urandom_range(0, 15)) +
          (16'($urandom_range(0, 15)) << 12);
      if ($urandom_range(0, 1) == 1 && known[a[11:0]]) begin
        rd_op(a, RDW, "rnd_rd");
        if ($urandom_range(0, 3) == 0) begin
          idle(2);
          chk("rnd_din_hold", 32'(bus.data_in), 32'(last_rd));
        end
      end else begin
        wr_op(a, 8'($urandom), "rnd_wr");
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
